// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing and datapath selects.
// Optional feature: define MC_CTRL_PERF_CNT_EN to add a 32-bit completed-instruction counter.
module mc_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic [5:0] func,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IRWE,
  output logic       PCWE,
  output logic [1:0] Reg_dst,
  output logic [1:0] MtoR,
  output logic [1:0] PC_src,
  output logic [1:0] s_type,
  output logic [3:0] ALUOP,
  output logic [2:0] Shift_ctrl,
  output logic       ALU_src,
  output logic       RWE,
  output logic       MWE,
  output logic [2:0] state
`ifdef MC_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] instr_cnt
`endif
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic       w_isAlu;
  logic       w_isLw;
  logic       w_isSw;
  logic       w_isBeq;
  logic       w_isJmp;
  logic       w_isJal;
  logic       w_isJr;
  logic [1:0] w_regDst;
  logic [1:0] w_mtoR;
  logic [1:0] w_pcSrc;
  logic [3:0] w_aluOp;
  logic [2:0] w_shiftCtrl;
  logic       w_aluSrc;

  // Instruction decode; unrecognised encodings leave everything at zero and run as a no-op.
  always_comb begin
    w_isAlu     = 1'b0;
    w_isLw      = 1'b0;
    w_isSw      = 1'b0;
    w_isBeq     = 1'b0;
    w_isJmp     = 1'b0;
    w_isJal     = 1'b0;
    w_isJr      = 1'b0;
    w_regDst    = 2'd0;
    w_mtoR      = 2'd0;
    w_pcSrc     = 2'd0;
    w_aluOp     = 4'd0;
    w_shiftCtrl = 3'd0;
    w_aluSrc    = 1'b0;
    case (OP)
      6'h00: begin
        case (func)
          6'h21: begin w_isAlu = 1'b1; w_regDst = 2'd1; w_aluOp = 4'd0; end
          6'h23: begin w_isAlu = 1'b1; w_regDst = 2'd1; w_aluOp = 4'd1; end
          6'h00: begin w_isAlu = 1'b1; w_regDst = 2'd1; w_aluOp = 4'd4; end
          6'h08: begin w_isJr  = 1'b1; w_pcSrc  = 2'd3; end
          default: ;
        endcase
      end
      6'h0D: begin w_isAlu = 1'b1; w_aluOp = 4'd2; w_aluSrc = 1'b1; w_shiftCtrl = 3'd0; end
      6'h0F: begin w_isAlu = 1'b1; w_aluOp = 4'd3; w_aluSrc = 1'b1; w_shiftCtrl = 3'd2; end
      6'h23: begin w_isLw  = 1'b1; w_aluSrc = 1'b1; w_shiftCtrl = 3'd1; w_mtoR = 2'd1; end
      6'h2B: begin w_isSw  = 1'b1; w_aluSrc = 1'b1; w_shiftCtrl = 3'd1; end
      6'h04: begin w_isBeq = 1'b1; w_aluOp = 4'd1; w_shiftCtrl = 3'd1; w_pcSrc = 2'd1; end
      6'h02: begin w_isJmp = 1'b1; w_pcSrc = 2'd2; end
      6'h03: begin w_isJal = 1'b1; w_pcSrc = 2'd2; w_regDst = 2'd2; w_mtoR = 2'd2; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:  w_next = mem_ready ? DECODE : FETCH;
      DECODE: w_next = EXEC;
      EXEC: begin
        if (w_isAlu)               w_next = WB;
        else if (w_isLw || w_isSw) w_next = MEM;
        else                       w_next = FETCH;
      end
      MEM: begin
        if (!mem_ready)  w_next = MEM;
        else if (w_isLw) w_next = WB;
        else             w_next = FETCH;
      end
      WB:      w_next = FETCH;
      default: w_next = FETCH;
    endcase
  end

  // Selects follow the decode for the whole EXEC..WB span; enables are killed while reset is low.
  always_comb begin
    mem_req    = 1'b0;
    IRWE       = 1'b0;
    PCWE       = 1'b0;
    RWE        = 1'b0;
    MWE        = 1'b0;
    Reg_dst    = 2'd0;
    MtoR       = 2'd0;
    PC_src     = 2'd0;
    s_type     = 2'd0;
    ALUOP      = 4'd0;
    Shift_ctrl = 3'd0;
    ALU_src    = 1'b0;
    if (r_state == EXEC || r_state == MEM || r_state == WB) begin
      Reg_dst    = w_regDst;
      MtoR       = w_mtoR;
      PC_src     = w_pcSrc;
      ALUOP      = w_aluOp;
      Shift_ctrl = w_shiftCtrl;
      ALU_src    = w_aluSrc;
    end
    case (r_state)
      FETCH: begin
        mem_req = 1'b1;
        IRWE    = mem_ready;
        PCWE    = mem_ready;
      end
      EXEC: begin
        PCWE = w_isJmp | w_isJal | w_isJr | (w_isBeq & Zero);
        RWE  = w_isJal;
      end
      MEM: begin
        mem_req = 1'b1;
        MWE     = w_isSw;
      end
      WB:      RWE = 1'b1;
      default: ;
    endcase
    if (!reset) begin
      mem_req = 1'b0;
      IRWE    = 1'b0;
      PCWE    = 1'b0;
      RWE     = 1'b0;
      MWE     = 1'b0;
    end
  end

  assign state = r_state;

`ifdef MC_CTRL_PERF_CNT_EN
  logic [31:0] r_instrCnt;

  always_ff @(posedge clk) begin
    if (!reset)
      r_instrCnt <= 32'd0;
    else if (r_state != FETCH && w_next == FETCH)
      r_instrCnt <= r_instrCnt + 32'd1;
  end

  assign instr_cnt = r_instrCnt;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: table of single-instruction vectors plus hand sequences for
// reset, FETCH/MEM wait states, lw, and reset during a sw memory wait.
module tb_mc_ctrl;

  logic        clk;
  logic        reset;
  logic [5:0]  OP;
  logic [5:0]  func;
  logic        Zero;
  logic        mem_ready;
  logic        mem_req;
  logic        IRWE;
  logic        PCWE;
  logic [1:0]  Reg_dst;
  logic [1:0]  MtoR;
  logic [1:0]  PC_src;
  logic [1:0]  s_type;
  logic [3:0]  ALUOP;
  logic [2:0]  Shift_ctrl;
  logic        ALU_src;
  logic        RWE;
  logic        MWE;
  logic [2:0]  state;
`ifdef MC_CTRL_PERF_CNT_EN
  logic [31:0] instr_cnt;
`endif

  int testsRun = 0;
  int testsFailed = 0;
  int expCnt = 0;

  mc_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .OP         (OP),
    .func       (func),
    .Zero       (Zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .IRWE       (IRWE),
    .PCWE       (PCWE),
    .Reg_dst    (Reg_dst),
    .MtoR       (MtoR),
    .PC_src     (PC_src),
    .s_type     (s_type),
    .ALUOP      (ALUOP),
    .Shift_ctrl (Shift_ctrl),
    .ALU_src    (ALU_src),
    .RWE        (RWE),
    .MWE        (MWE),
    .state      (state)
`ifdef MC_CTRL_PERF_CNT_EN
    ,
    .instr_cnt  (instr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bundle order: PCWE,RWE,MWE,mem_req,Reg_dst,MtoR,PC_src,ALUOP,Shift_ctrl,ALU_src
  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        zero;
    logic [17:0] exp;
    logic [2:0]  next;
  } vec_t;

  function automatic logic [17:0] mkExp(input logic pcwe, input logic rwe, input logic [1:0] rd,
                                        input logic [1:0] mtor, input logic [1:0] pcsrc,
                                        input logic [3:0] aluop, input logic [2:0] sh,
                                        input logic src);
    return {pcwe, rwe, 1'b0, 1'b0, rd, mtor, pcsrc, aluop, sh, src};
  endfunction

  function automatic logic [17:0] actBundle();
    return {PCWE, RWE, MWE, mem_req, Reg_dst, MtoR, PC_src, ALUOP, Shift_ctrl, ALU_src};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input logic rdy);
    reset     = rst;
    OP        = op;
    func      = fn;
    Zero      = z;
    mem_ready = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs FETCH with `delay` idle cycles, then DECODE, and leaves the FSM in EXEC.
  task automatic fetchInstr(input logic [5:0] op, input logic [5:0] fn, input int delay);
    for (int i = 0; i < delay; i++) begin
      applyStimulus(1'b1, op, fn, 1'b0, 1'b0);
      checkOutput("fetch_wait_state", {29'd0, state}, 32'd0);
      checkOutput("fetch_wait_req_ir", {30'd0, mem_req, IRWE}, 32'h2);
      tick();
    end
    applyStimulus(1'b1, op, fn, 1'b0, 1'b1);
    checkOutput("fetch_done_req_ir_pc", {28'd0, mem_req, IRWE, PCWE, PC_src == 2'd0}, 32'hF);
    tick();
    applyStimulus(1'b1, op, fn, 1'b0, 1'b1);
    checkOutput("decode_state", {29'd0, state}, 32'd1);
    checkOutput("decode_no_enables", {27'd0, mem_req, IRWE, PCWE, RWE, MWE}, 32'd0);
    tick();
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{6'h00, 6'h21, 1'b0, mkExp(0, 0, 2'd1, 2'd0, 2'd0, 4'd0, 3'd0, 0), 3'd4};
    vecs[1]  = '{6'h00, 6'h23, 1'b0, mkExp(0, 0, 2'd1, 2'd0, 2'd0, 4'd1, 3'd0, 0), 3'd4};
    vecs[2]  = '{6'h00, 6'h00, 1'b0, mkExp(0, 0, 2'd1, 2'd0, 2'd0, 4'd4, 3'd0, 0), 3'd4};
    vecs[3]  = '{6'h00, 6'h08, 1'b0, mkExp(1, 0, 2'd0, 2'd0, 2'd3, 4'd0, 3'd0, 0), 3'd0};
    vecs[4]  = '{6'h0D, 6'h15, 1'b0, mkExp(0, 0, 2'd0, 2'd0, 2'd0, 4'd2, 3'd0, 1), 3'd4};
    vecs[5]  = '{6'h0F, 6'h00, 1'b0, mkExp(0, 0, 2'd0, 2'd0, 2'd0, 4'd3, 3'd2, 1), 3'd4};
    vecs[6]  = '{6'h04, 6'h00, 1'b1, mkExp(1, 0, 2'd0, 2'd0, 2'd1, 4'd1, 3'd1, 0), 3'd0};
    vecs[7]  = '{6'h04, 6'h00, 1'b0, mkExp(0, 0, 2'd0, 2'd0, 2'd1, 4'd1, 3'd1, 0), 3'd0};
    vecs[8]  = '{6'h02, 6'h00, 1'b0, mkExp(1, 0, 2'd0, 2'd0, 2'd2, 4'd0, 3'd0, 0), 3'd0};
    vecs[9]  = '{6'h03, 6'h00, 1'b0, mkExp(1, 1, 2'd2, 2'd2, 2'd2, 4'd0, 3'd0, 0), 3'd0};
    vecs[10] = '{6'h3F, 6'h00, 1'b1, mkExp(0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 3'd0, 0), 3'd0};
    vecs[11] = '{6'h00, 6'h3F, 1'b1, mkExp(0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 3'd0, 0), 3'd0};

    // Reset held low for three cycles with a stray mem_ready.
    applyStimulus(1'b0, 6'h00, 6'h21, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      applyStimulus(1'b0, 6'h00, 6'h21, 1'b0, 1'b1);
      checkOutput("reset_state", {29'd0, state}, 32'd0);
      checkOutput("reset_enables", {27'd0, mem_req, IRWE, PCWE, RWE, MWE}, 32'd0);
    end
`ifdef MC_CTRL_PERF_CNT_EN
    checkOutput("reset_cnt", instr_cnt, 32'd0);
`endif
    applyStimulus(1'b1, 6'h00, 6'h21, 1'b0, 1'b0);
    checkOutput("release_fetch_req", {28'd0, state, mem_req}, 32'h1);

    // addu with a two-cycle fetch wait, then WB.
    fetchInstr(6'h00, 6'h21, 2);
    applyStimulus(1'b1, 6'h00, 6'h21, 1'b0, 1'b0);
    checkOutput("addu_exec", {29'd0, state}, 32'd2);
    checkOutput("addu_exec_rwe", {31'd0, RWE}, 32'd0);
    tick();
    applyStimulus(1'b1, 6'h00, 6'h21, 1'b0, 1'b0);
    checkOutput("addu_wb", {25'd0, state, RWE, Reg_dst, MtoR}, {25'd0, 3'd4, 1'b1, 2'd1, 2'd0});
    tick();
    expCnt++;
    applyStimulus(1'b1, 6'h00, 6'h21, 1'b0, 1'b0);
    checkOutput("addu_back_fetch", {29'd0, state}, 32'd0);

    // Table of single-instruction vectors with immediate fetch acknowledge.
    for (int v = 0; v < 12; v++) begin
      fetchInstr(vecs[v].op, vecs[v].fn, 0);
      applyStimulus(1'b1, vecs[v].op, vecs[v].fn, vecs[v].zero, 1'b0);
      checkOutput($sformatf("vec%0d_exec_state", v), {29'd0, state}, 32'd2);
      checkOutput($sformatf("vec%0d_exec_outputs", v), {14'd0, actBundle()}, {14'd0, vecs[v].exp});
      tick();
      applyStimulus(1'b1, vecs[v].op, vecs[v].fn, vecs[v].zero, 1'b0);
      checkOutput($sformatf("vec%0d_next_state", v), {29'd0, state}, {29'd0, vecs[v].next});
      if (vecs[v].next == 3'd4) begin
        checkOutput($sformatf("vec%0d_wb_outputs", v), {14'd0, actBundle()},
                    {14'd0, vecs[v].exp | 18'h10000});
        tick();
        applyStimulus(1'b1, vecs[v].op, vecs[v].fn, vecs[v].zero, 1'b0);
        checkOutput($sformatf("vec%0d_final_fetch", v), {29'd0, state}, 32'd0);
      end
      expCnt++;
    end
`ifdef MC_CTRL_PERF_CNT_EN
    checkOutput("cnt_after_table", instr_cnt, expCnt);
`endif

    // lw with four MEM wait cycles.
    fetchInstr(6'h23, 6'h00, 0);
    applyStimulus(1'b1, 6'h23, 6'h00, 1'b0, 1'b0);
    checkOutput("lw_exec", {14'd0, actBundle()}, {14'd0, mkExp(0, 0, 2'd0, 2'd1, 2'd0, 4'd0, 3'd1, 1)});
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 6'h23, 6'h00, 1'b0, 1'b0);
      checkOutput("lw_mem_wait", {26'd0, state, mem_req, RWE, MWE}, {26'd0, 3'd3, 3'b100});
      tick();
    end
    applyStimulus(1'b1, 6'h23, 6'h00, 1'b0, 1'b1);
    checkOutput("lw_mem_done", {26'd0, state, mem_req, RWE, MWE}, {26'd0, 3'd3, 3'b100});
    tick();
    applyStimulus(1'b1, 6'h23, 6'h00, 1'b0, 1'b1);
    checkOutput("lw_wb", {24'd0, state, RWE, mem_req, Reg_dst, MtoR}, {24'd0, 3'd4, 1'b1, 1'b0, 2'd0, 2'd1});
    tick();
    expCnt++;
    applyStimulus(1'b1, 6'h23, 6'h00, 1'b0, 1'b0);
    checkOutput("lw_back_fetch", {29'd0, state}, 32'd0);

    // sw completing normally.
    fetchInstr(6'h2B, 6'h00, 0);
    tick();
    applyStimulus(1'b1, 6'h2B, 6'h00, 1'b0, 1'b1);
    checkOutput("sw_mem", {26'd0, state, mem_req, MWE, RWE}, {26'd0, 3'd3, 3'b110});
    tick();
    expCnt++;
    applyStimulus(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0);
    checkOutput("sw_back_fetch", {28'd0, state, MWE}, 32'd0);
`ifdef MC_CTRL_PERF_CNT_EN
    checkOutput("cnt_before_abort", instr_cnt, expCnt);
`endif

    // sw aborted by reset during its MEM wait.
    fetchInstr(6'h2B, 6'h00, 1);
    tick();
    applyStimulus(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0);
    checkOutput("sw_wait_mwe", {26'd0, state, mem_req, MWE, RWE}, {26'd0, 3'd3, 3'b110});
    applyStimulus(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0);
    checkOutput("sw_abort_enables", {27'd0, mem_req, IRWE, PCWE, RWE, MWE}, 32'd0);
    tick();
    applyStimulus(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0);
    checkOutput("sw_abort_fetch", {28'd0, state, mem_req}, 32'h1);
`ifdef MC_CTRL_PERF_CNT_EN
    checkOutput("cnt_after_abort", instr_cnt, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
